bram_port_arbiter: RTL and testbench

Two-requester arbiter that shares one 32-bit, byte-write-enabled, single-port BRAM between two bus masters, for example the CPU data port and a debug/DMA loader. It sits directly in front of the BRAM wrapper and drives that wrapper's byte address, 4-bit write enable and write data. It also returns the wrapper's one-cycle-latency read data to whichever requester won. Arbitration is round-robin, with a fixed-priority fallback.

---
 rtl/bram_port_arbiter_if.sv | 25 ++
 rtl/bram_port_arbiter.sv | 124 ++++++++++++
 tb/tb_bram_port_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus for bram_port_arbiter: one instance per bus master.
// The master modport drives the request, the slave modport (the arbiter)
// returns the accept pulse and the registered read response.
interface bram_port_arbiter_if #(
   parameter int address_width = 32,
   parameter int data_width    = 32
);
   logic                     valid;
   logic [address_width-1:0] addr;
   logic [3:0]               wstrb;
   logic [data_width-1:0]    wdata;
   logic                     ready;
   logic                     rvalid;
   logic [data_width-1:0]    rdata;

   modport master (
      output valid, addr, wstrb, wdata,
      input  ready, rvalid, rdata
   );

   modport slave (
      input  valid, addr, wstrb, wdata,
      output ready, rvalid, rdata
   );
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one 32-bit byte-write-enabled single-port BRAM
// between two requesters. Each access is latched in IDLE, issued in GRANT,
// and for reads the one-cycle-latency BRAM data is captured in RESP.
// Optional feature macro: BRAM_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin tie-break using last_grant
//   undefined -> fixed priority, port 0 wins ties
module bram_port_arbiter #(
   parameter int address_width = 32,
   parameter int data_width    = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   bram_port_arbiter_if.slave       m0,
   bram_port_arbiter_if.slave       m1,
   output logic [address_width-1:0] mem_addr,
   output logic [3:0]               mem_wr,
   output logic [data_width-1:0]    mem_din,
   input  logic [data_width-1:0]    mem_dout
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      RESP
   } state_t;

   state_t                   state;
   logic                     winner;
   logic                     pick;
   logic [address_width-3:0] lat_addr;
   logic [3:0]               lat_wstrb;
   logic [data_width-1:0]    lat_wdata;
   logic [data_width-1:0]    rdata_q;
   logic                     rvalid0_q;
   logic                     rvalid1_q;

`ifdef BRAM_ARB_ROUND_ROBIN_EN
   logic last_grant;

   // Tie goes to whichever port did not win the previous arbitration
   always_comb begin
      pick = 1'b0;
      if (m0.valid && m1.valid) begin
         pick = ~last_grant;
      end else if (m1.valid) begin
         pick = 1'b1;
      end
   end

   // Remember the most recent winner; reset value makes port 0 win the first tie
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b1;
      end else if (state == IDLE && (m0.valid || m1.valid)) begin
         last_grant <= pick;
      end
   end
`else
   // Fixed priority: port 1 only wins when port 0 is not requesting
   always_comb begin
      pick = 1'b0;
      if (!m0.valid && m1.valid) begin
         pick = 1'b1;
      end
   end
`endif

   // Main sequencer: latch the winning request, issue it, capture read data
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         winner    <= 1'b0;
         lat_addr  <= '0;
         lat_wstrb <= '0;
         lat_wdata <= '0;
         rdata_q   <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         case (state)
            IDLE: begin
               if (m0.valid || m1.valid) begin
                  state     <= GRANT;
                  winner    <= pick;
                  lat_addr  <= pick ? m1.addr[address_width-1:2] : m0.addr[address_width-1:2];
                  lat_wstrb <= pick ? m1.wstrb : m0.wstrb;
                  lat_wdata <= pick ? m1.wdata : m0.wdata;
               end
            end
            GRANT: begin
               state <= (lat_wstrb == 4'b0000) ? RESP : IDLE;
            end
            RESP: begin
               rdata_q <= mem_dout;
               if (winner) begin
                  rvalid1_q <= 1'b1;
               end else begin
                  rvalid0_q <= 1'b1;
               end
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // BRAM side: address and data hold the latched request, strobes only in GRANT
   assign mem_addr = {lat_addr, 2'b00};
   assign mem_din  = lat_wdata;
   assign mem_wr   = (state == GRANT && !reset) ? lat_wstrb : 4'b0000;

   // Requester side: accept pulse during GRANT, shared read-data register
   assign m0.ready  = (state == GRANT) && !winner && !reset;
   assign m1.ready  = (state == GRANT) &&  winner && !reset;
   assign m0.rvalid = rvalid0_q;
   assign m1.rvalid = rvalid1_q;
   assign m0.rdata  = rdata_q;
   assign m1.rdata  = rdata_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter with a behavioural BRAM and a
// grant/response scoreboard. Expected grant order adapts to
// BRAM_ARB_ROUND_ROBIN_EN.
module tb_bram_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout = '0;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      bit          port;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          rcyc;
   } txn_t;

   txn_t grant_q[$];
   txn_t resp_q[$];

   logic [31:0] bram [0:63];

   bram_port_arbiter_if m0_bus ();
   bram_port_arbiter_if m1_bus ();

   bram_port_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .m0       (m0_bus),
      .m1       (m1_bus),
      .mem_addr (mem_addr),
      .mem_wr   (mem_wr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used for latency expectations
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural single-port BRAM with byte enables and one-cycle read latency
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (mem_wr[b]) bram[mem_addr[7:2]][8*b +: 8] <= mem_din[8*b +: 8];
      end
      mem_dout <= bram[mem_addr[7:2]];
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at cycle %0d", tag, observed, expected, cyc);
      end
   endtask

   // Scoreboard monitor: compares grants and read responses against the queues
   always @(negedge clk) begin
      txn_t t;
      if (m0_bus.ready && m1_bus.ready) checkOutput("dual_ready", 1, 0);
      if (m0_bus.ready || m1_bus.ready) begin
         if (grant_q.size() == 0) begin
            checkOutput("unexpected_ready", 1, 0);
         end else begin
            t = grant_q.pop_front();
            checkOutput("grant_port", {63'd0, m1_bus.ready}, {63'd0, t.port});
            checkOutput("grant_mem_addr", {32'd0, mem_addr}, {32'd0, t.addr[31:2], 2'b00});
            checkOutput("grant_mem_wr", {60'd0, mem_wr}, {60'd0, t.wstrb});
            if (t.wstrb != 4'b0000) checkOutput("grant_mem_din", {32'd0, mem_din}, {32'd0, t.wdata});
            else resp_q.push_back(t);
         end
      end else begin
         checkOutput("mem_wr_idle", {60'd0, mem_wr}, 64'd0);
      end
      if (m0_bus.rvalid && m1_bus.rvalid) checkOutput("dual_rvalid", 1, 0);
      if (m0_bus.rvalid || m1_bus.rvalid) begin
         if (resp_q.size() == 0) begin
            checkOutput("unexpected_rvalid", 1, 0);
         end else begin
            t = resp_q.pop_front();
            checkOutput("rvalid_port", {63'd0, m1_bus.rvalid}, {63'd0, t.port});
            checkOutput("rdata", {32'd0, (t.port ? m1_bus.rdata : m0_bus.rdata)}, {32'd0, t.rdata});
            if (t.rcyc >= 0) checkOutput("rvalid_latency", cyc, t.rcyc);
         end
      end
   end

   // Drive one request on a port and hold it until accepted (bounded wait)
   task automatic applyStimulus(input bit port, input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
      bit got = 0;
      if (port) begin
         m1_bus.valid = 1'b1; m1_bus.addr = addr; m1_bus.wstrb = wstrb; m1_bus.wdata = wdata;
      end else begin
         m0_bus.valid = 1'b1; m0_bus.addr = addr; m0_bus.wstrb = wstrb; m0_bus.wdata = wdata;
      end
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (port ? m1_bus.ready : m0_bus.ready) begin
            got = 1;
            break;
         end
      end
      if (!got) checkOutput(port ? "ready_timeout_m1" : "ready_timeout_m0", 0, 1);
      @(posedge clk);
      #1;
      if (port) m1_bus.valid = 1'b0;
      else m0_bus.valid = 1'b0;
   endtask

   // Wait (bounded) until every expected grant and response has been seen
   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (grant_q.size() == 0 && resp_q.size() == 0) break;
      end
      @(negedge clk);
   endtask

   // Single isolated access from an idle arbiter, with exact read latency
   task automatic single(input bit port, input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata, input logic [31:0] rdata);
      txn_t t;
      t.port = port; t.addr = addr; t.wstrb = wstrb; t.wdata = wdata; t.rdata = rdata;
      t.rcyc = cyc + 3;
      grant_q.push_back(t);
      applyStimulus(port, addr, wstrb, wdata);
      drain();
   endtask

   // Push an expected grant/response without a latency constraint
   task automatic expectGrant(input bit port, input logic [31:0] addr, input logic [31:0] rdata);
      txn_t t;
      t.port = port; t.addr = addr; t.wstrb = 4'b0000; t.wdata = '0; t.rdata = rdata; t.rcyc = -1;
      grant_q.push_back(t);
   endtask

   // Watchdog so the run always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence
   initial begin
      txn_t t;
      m0_bus.valid = 0; m0_bus.addr = '0; m0_bus.wstrb = '0; m0_bus.wdata = '0;
      m1_bus.valid = 0; m1_bus.addr = '0; m1_bus.wstrb = '0; m1_bus.wdata = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_m0_ready", {63'd0, m0_bus.ready}, 0);
      checkOutput("reset_m1_ready", {63'd0, m1_bus.ready}, 0);
      checkOutput("reset_m0_rvalid", {63'd0, m0_bus.rvalid}, 0);
      checkOutput("reset_m1_rvalid", {63'd0, m1_bus.rvalid}, 0);
      checkOutput("reset_rdata", {32'd0, m0_bus.rdata}, 0);
      checkOutput("reset_mem_addr", {32'd0, mem_addr}, 0);
      checkOutput("reset_mem_din", {32'd0, mem_din}, 0);
      checkOutput("reset_mem_wr", {60'd0, mem_wr}, 0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] single write then read");
      single(0, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0);
      single(0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF);

      $display("[TB] byte lanes");
      single(0, 32'h14, 4'hF, 32'h11223344, 32'h0);
      single(0, 32'h14, 4'h1, 32'h000000AA, 32'h0);
      single(0, 32'h14, 4'h0, 32'h0, 32'h112233AA);

      $display("[TB] unaligned read on port 1");
      single(1, 32'h13, 4'h0, 32'h0, 32'hDEADBEEF);

      $display("[TB] contention");
`ifdef BRAM_ARB_ROUND_ROBIN_EN
      expectGrant(0, 32'h10, 32'hDEADBEEF);
      expectGrant(1, 32'h14, 32'h112233AA);
      expectGrant(0, 32'h10, 32'hDEADBEEF);
      expectGrant(1, 32'h14, 32'h112233AA);
      expectGrant(0, 32'h10, 32'hDEADBEEF);
      expectGrant(0, 32'h10, 32'hDEADBEEF);
`else
      expectGrant(0, 32'h10, 32'hDEADBEEF);
      expectGrant(0, 32'h10, 32'hDEADBEEF);
      expectGrant(0, 32'h10, 32'hDEADBEEF);
      expectGrant(0, 32'h10, 32'hDEADBEEF);
      expectGrant(1, 32'h14, 32'h112233AA);
      expectGrant(1, 32'h14, 32'h112233AA);
`endif
      fork
         begin
            repeat (4) applyStimulus(0, 32'h10, 4'h0, 32'h0);
         end
         begin
            repeat (2) applyStimulus(1, 32'h14, 4'h0, 32'h0);
         end
      join
      drain();

      $display("[TB] reset during write grant");
      single(1, 32'h20, 4'hF, 32'hCAFEF00D, 32'h0);
      m0_bus.valid = 1'b1; m0_bus.addr = 32'h20; m0_bus.wstrb = 4'hF; m0_bus.wdata = 32'h55;
      @(posedge clk);
      #1;
      reset = 1'b1;
      m0_bus.valid = 1'b0;
      @(negedge clk);
      checkOutput("reset_grant_ready", {63'd0, m0_bus.ready}, 0);
      checkOutput("reset_grant_mem_wr", {60'd0, mem_wr}, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      single(1, 32'h20, 4'h0, 32'h0, 32'hCAFEF00D);

      $display("[TB] reset during read response");
      t.port = 0; t.addr = 32'h10; t.wstrb = 4'h0; t.wdata = '0; t.rdata = 32'hDEADBEEF; t.rcyc = -1;
      grant_q.push_back(t);
      m0_bus.valid = 1'b1; m0_bus.addr = 32'h10; m0_bus.wstrb = 4'h0; m0_bus.wdata = 32'h0;
      @(posedge clk);
      @(posedge clk);
      #1;
      m0_bus.valid = 1'b0;
      reset = 1'b1;
      resp_q.delete();
      @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("discarded_rdata", {32'd0, m0_bus.rdata}, 0);
      repeat (5) @(negedge clk);

      checkOutput("grant_q_empty", grant_q.size(), 0);
      checkOutput("resp_q_empty", resp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
